// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-2 Booth sequential multiplier.
// Provides the FSM state enum, Booth operation enum, default width and op decoder.
package booth_pkg;

    localparam int DEF_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_ADD,
        OP_SUB
    } op_t;

    // Booth recoding of the current multiplier bit pair {Q[0], q_m1}.
    function automatic op_t booth_op(input logic q0, input logic q_m1);
        op_t op;
        unique case ({q0, q_m1})
            2'b01:   op = OP_ADD;
            2'b10:   op = OP_SUB;
            default: op = OP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_step.sv
// One Booth iteration: add/subtract M into A, then arithmetic right shift of {A, Q, q_m1}.
// Ports: a/q/q_m1/m working state in; a_next/q_next/q_m1_next shifted state out. Purely combinational.
module booth_step
    import booth_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic             q_m1,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH:0]   a_next,
    output logic [WIDTH-1:0] q_next,
    output logic             q_m1_next
);

    logic [WIDTH:0] sum;

    // WIDTH+1-bit wrap-around arithmetic; the extra bit keeps -M exact for M = -2^(WIDTH-1).
    always_comb begin
        sum = a;
        unique case (booth_op(q[0], q_m1))
            OP_ADD:  sum = a + m;
            OP_SUB:  sum = a - m;
            default: sum = a;
        endcase
    end

    assign a_next    = {sum[WIDTH], sum[WIDTH:1]};
    assign q_next    = {sum[0], q[WIDTH-1:1]};
    assign q_m1_next = q[0];

endmodule

// File: rtl/booth_seq_mult.sv
// Radix-2 Booth sequential signed multiplier with start/busy/done handshake.
// Ports: clk, rst (sync, active-high), start, multiplicand, multiplier -> busy, done, product.
// Optional macro BOOTH_EARLY_TERM_EN: finish with one barrel shift once the
// remaining multiplier bits can only produce pure shifts.
module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    state_t state;
    state_t state_next;

    logic [WIDTH:0]   a;
    logic [WIDTH:0]   m;
    logic [WIDTH:0]   a_step;
    logic [WIDTH:0]   a_fin;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] q_fin;
    logic             q_m1;
    logic             q_m1_step;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_dec;
    logic [CNT_W-1:0] cnt_fin;
    logic             early;
    logic             last;

    booth_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .a         (a),
        .q         (q),
        .q_m1      (q_m1),
        .m         (m),
        .a_next    (a_step),
        .q_next    (q_step),
        .q_m1_next (q_m1_step)
    );

    assign cnt_dec = cnt - CNT_W'(1);

`ifdef BOOTH_EARLY_TERM_EN
    logic [WIDTH:0]          mask;
    logic signed [2*WIDTH:0] shifted;

    // After this step, cnt_dec bits remain unprocessed. If they all equal
    // q_m1, every remaining Booth op is OP_NONE, so only shifts are left.
    assign mask    = ((WIDTH + 1)'(1) << cnt_dec) - (WIDTH + 1)'(1);
    assign early   = ((({1'b0, q_step} ^ {(WIDTH + 1){q_m1_step}}) & mask) == '0);
    assign shifted = $signed({a_step, q_step}) >>> cnt_dec;
    assign a_fin   = shifted[2*WIDTH:WIDTH];
    assign q_fin   = shifted[WIDTH-1:0];
`else
    assign early = 1'b0;
    assign a_fin = a_step;
    assign q_fin = q_step;
`endif

    assign cnt_fin = early ? '0 : cnt_dec;
    assign last    = (cnt_fin == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Product is captured on the last CALC edge so it is valid during DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            a       <= '0;
            q       <= '0;
            q_m1    <= 1'b0;
            m       <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m    <= {multiplicand[WIDTH-1], multiplicand};
                        q    <= multiplier;
                        a    <= '0;
                        q_m1 <= 1'b0;
                        cnt  <= CNT_W'(WIDTH);
                    end
                end
                CALC: begin
                    a    <= a_fin;
                    q    <= q_fin;
                    q_m1 <= q_m1_step;
                    cnt  <= cnt_fin;
                    if (last) begin
                        product <= {a_fin[WIDTH-1:0], q_fin};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Scoreboard bench for booth_seq_mult (WIDTH=16).
// Expected products are queued at issue and compared when done pulses.
module tb_booth_seq_mult;

    localparam int W = 16;
`ifdef BOOTH_EARLY_TERM_EN
    localparam int LAT = -1;
`else
    localparam int LAT = 17;
`endif

    typedef struct {
        logic [2*W-1:0] prod;
        int             t;
        int             lat;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   mcand;
    logic [W-1:0]   mplier;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   dones = 0;
    int   last_done = -1;
    int   gap_exp = 0;
    logic prev_done = 1'b0;
    exp_t sb[$];
    exp_t e;

    booth_seq_mult #(
        .WIDTH(W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (mcand),
        .multiplier   (mplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic signed [2*W-1:0] r;
        r = $signed(a) * $signed(b);
        return r;
    endfunction

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (prev_done) begin
                check("done_pulse", {63'd0, done}, 64'd0);
            end
            if (done === 1'b1) begin
                dones++;
                if (sb.size() == 0) begin
                    check("sb_empty", 64'(sb.size()), 64'd1);
                end else begin
                    e = sb.pop_front();
                    check("product", {32'd0, product}, {32'd0, e.prod});
                    if (e.lat >= 0) begin
                        check("latency", 64'(cyc - e.t), 64'(e.lat));
                    end
                end
                if (gap_exp > 0 && last_done >= 0) begin
                    check("gap", 64'(cyc - last_done), 64'(gap_exp));
                end
                last_done = cyc;
            end
        end
        prev_done = (done === 1'b1) && !rst;
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] x, input int lat);
        @(negedge clk);
        start  = 1'b1;
        mcand  = a;
        mplier = b;
        sb.push_back('{x, cyc, lat});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            check("timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_done(input int d0);
        int k = 0;
        while (dones == d0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (dones == d0) begin
            check("done_timeout", 64'(dones), 64'(d0 + 1));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           d0;

        rst    = 1'b1;
        start  = 1'b0;
        mcand  = '0;
        mplier = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_product", {32'd0, product}, 64'd0);
        rst = 1'b0;

        issue(16'd3, 16'd5, 32'h0000_000F, LAT);
        check("busy_rise", {63'd0, busy}, 64'd1);
        wait_idle();

        issue(16'hFFF9, 16'd6, 32'hFFFF_FFD6, LAT);
        wait_idle();
        issue(16'h8000, 16'h8000, 32'h4000_0000, LAT);
        wait_idle();
        issue(16'h7FFF, 16'h8000, 32'hC000_8000, LAT);
        wait_idle();

        issue(16'd100, 16'h5555, 32'h0021_5534, LAT);
        repeat (4) @(negedge clk);
        start  = 1'b1;
        mcand  = 16'h7777;
        mplier = 16'h1111;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_idle();

        issue(16'h1234, 16'h5555, model(16'h1234, 16'h5555), LAT);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        check("mid_rst_done", {63'd0, done}, 64'd0);
        check("mid_rst_product", {32'd0, product}, 64'd0);
        issue(16'd9, 16'd9, 32'd81, LAT);
        wait_idle();

        @(negedge clk);
        start  = 1'b1;
        mcand  = 16'd2;
        mplier = 16'd2;
        sb.push_back('{32'd4, cyc, LAT});
        d0 = dones;
        wait_done(d0);
        mcand  = 16'hFFFF;
        mplier = 16'hFFFF;
        sb.push_back('{32'd1, 0, -1});
`ifndef BOOTH_EARLY_TERM_EN
        gap_exp = 18;
`endif
        d0 = dones;
        wait_done(d0);
        mcand  = 16'd0;
        mplier = 16'h1234;
        sb.push_back('{32'd0, 0, -1});
        d0 = dones;
        wait_done(d0);
        start = 1'b0;
        wait_idle();
        gap_exp = 0;

`ifdef BOOTH_EARLY_TERM_EN
        issue(16'd3, 16'd1, 32'd3, 3);
        wait_idle();
`endif

        for (int i = 0; i < 300; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 8 == 0) rb = 16'h8000;
            if (i % 8 == 1) ra = 16'hFFFF;
            issue(ra, rb, model(ra, rb), LAT);
            wait_idle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
